// File: rtl/pakout_rr_if.sv
// ---------------------------------------------------------------------------
// pakout_rr_if
//   Handshake bundle for the multi-channel packet-out block.
//   Receive side : NCH four-phase message channels (rcv_req/rcv_msg/rcv_ack).
//   Send side    : one four-phase packet channel (snd_req/snd_ack/snd_pakio),
//                  qualified by snd_last (final packet of a message) and
//                  snd_src (channel the current message came from).
//   snd_par (even parity of snd_pakio) exists only when NS_PAKOUT_PARITY_EN
//   is defined.
//   Modports:
//     master : the packet-out block (consumes messages, produces packets)
//     slave  : its environment (produces messages, consumes packets)
// ---------------------------------------------------------------------------
interface pakout_rr_if #(
  parameter int NCH  = 2,
  parameter int MSZ  = 18,
  parameter int PSZ  = 8,
  parameter int SRCW = 1
);
  logic [NCH-1:0]     rcv_req;
  logic [NCH*MSZ-1:0] rcv_msg;
  logic [NCH-1:0]     rcv_ack;
  logic               snd_req;
  logic               snd_ack;
  logic [PSZ-1:0]     snd_pakio;
  logic               snd_last;
  logic [SRCW-1:0]    snd_src;
`ifdef NS_PAKOUT_PARITY_EN
  logic               snd_par;
`endif

  modport master (
    input  rcv_req,
    input  rcv_msg,
    input  snd_ack,
    output rcv_ack,
    output snd_req,
    output snd_pakio,
    output snd_last,
`ifdef NS_PAKOUT_PARITY_EN
    output snd_par,
`endif
    output snd_src
  );

  modport slave (
    output rcv_req,
    output rcv_msg,
    output snd_ack,
    input  rcv_ack,
    input  snd_req,
    input  snd_pakio,
    input  snd_last,
`ifdef NS_PAKOUT_PARITY_EN
    input  snd_par,
`endif
    input  snd_src
  );
endinterface

// File: rtl/pakout_rr.sv
// ---------------------------------------------------------------------------
// pakout_rr
//   Multi-channel packet-out block. Whole messages {addr,data,redun} arrive on
//   NCH independent four-phase channels and are buffered in one FIFO per
//   channel. A round-robin arbiter drains the FIFOs into a single PSZ-wide
//   four-phase packet stream, NPK = ceil(MSZ/PSZ) packets per message, most
//   significant packet first (message zero-extended at the MSB side).
//
//   Ports:
//     i_clk    : sole clock, rising edge
//     reset_n  : asynchronous active-low reset
//     ready    : block initialised (first clock edge after reset release)
//     busy     : serializer active or any FIFO holds a message
//     bus      : pakout_rr_if.master (rcv_* message channels, snd_* packets)
//
//   Configuration macro:
//     NS_PAKOUT_PARITY_EN : adds bus.snd_par = even parity of bus.snd_pakio.
// ---------------------------------------------------------------------------
module pakout_rr #(
  parameter int NCH        = 2,
  parameter int PSZ        = 8,
  parameter int ASZ        = 6,
  parameter int DSZ        = 8,
  parameter int RSZ        = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         i_clk,
  input  logic         reset_n,
  output logic         ready,
  output logic         busy,
  pakout_rr_if.master  bus
);

  localparam int MSZ   = ASZ + DSZ + RSZ;
  localparam int NPK   = (MSZ + PSZ - 1) / PSZ;
  localparam int SHW   = NPK * PSZ;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SRCW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW    = (NPK > 1) ? $clog2(NPK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RELEASE
  } state_t;

  state_t             state;
  logic [SHW-1:0]     shreg;
  logic [CW-1:0]      pk_cnt;
  logic               snd_req_r;
  logic               snd_last_r;
  logic [SRCW-1:0]    snd_src_r;
  logic [SRCW-1:0]    rr_ptr;

  logic [NCH-1:0]     push;
  logic [NCH-1:0]     pop;
  logic [NCH-1:0]     nempty;
  logic [NCH-1:0]     full;
  logic [NCH*MSZ-1:0] head_flat;

  logic               grant_vld;
  logic [SRCW-1:0]    grant;

  // Channel index 'off' positions after 'base', wrapping at NCH.
  function automatic logic [SRCW-1:0] rr_idx(input logic [SRCW-1:0] base,
                                             input int off);
    int s;
    s = (int'(base) + off) % NCH;
    return SRCW'(s);
  endfunction

  // -------------------------------------------------------------------------
  // Per-channel input handshake and FIFO
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [MSZ-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  ack;

    assign nempty[g] = (cnt != '0);
    assign full[g]   = (cnt == (DEPTH_LOG2+1)'(DEPTH));
    // A full FIFO still accepts a push when the arbiter pops it in the same
    // cycle; otherwise the ack is withheld and the sender stalls.
    assign push[g]   = ready & bus.rcv_req[g] & ~ack & (~full[g] | pop[g]);
    assign head_flat[g*MSZ +: MSZ] = mem[rp];
    assign bus.rcv_ack[g] = ack;

    always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        ack <= 1'b0;
      end else begin
        if (push[g]) wp <= wp + 1'b1;
        if (pop[g])  rp <= rp + 1'b1;
        if (push[g] && !pop[g])      cnt <= cnt + 1'b1;
        else if (!push[g] && pop[g]) cnt <= cnt - 1'b1;
        if (push[g])                     ack <= 1'b1;
        else if (!bus.rcv_req[g] && ack) ack <= 1'b0;
      end
    end

    // Storage needs no reset: the occupancy count defines what is valid.
    always_ff @(posedge i_clk) begin
      if (push[g]) mem[wp] <= bus.rcv_msg[g*MSZ +: MSZ];
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: scan starting just after the last granted channel
  // -------------------------------------------------------------------------
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_ptr;
    for (int k = 1; k <= NCH; k++) begin
      if (!grant_vld && nempty[rr_idx(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant     = rr_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (ready && state == S_IDLE && grant_vld) pop[grant] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Serializer FSM: one four-phase handshake per packet
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      ready      <= 1'b0;
      state      <= S_IDLE;
      shreg      <= '0;
      pk_cnt     <= '0;
      snd_req_r  <= 1'b0;
      snd_last_r <= 1'b0;
      snd_src_r  <= '0;
      rr_ptr     <= SRCW'(NCH - 1);
    end else begin
      ready <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ready && grant_vld) begin
            shreg      <= SHW'(head_flat[int'(grant)*MSZ +: MSZ]);
            pk_cnt     <= '0;
            snd_src_r  <= grant;
            rr_ptr     <= grant;
            snd_req_r  <= 1'b1;
            snd_last_r <= (NPK == 1);
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.snd_ack) begin
            snd_req_r <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Payload, last and source stay put until the consumer drops ack.
          if (!bus.snd_ack) begin
            if (snd_last_r) begin
              snd_last_r <= 1'b0;
              state      <= S_IDLE;
            end else begin
              shreg      <= shreg << PSZ;
              pk_cnt     <= pk_cnt + 1'b1;
              snd_last_r <= (pk_cnt == CW'(NPK - 2));
              snd_req_r  <= 1'b1;
              state      <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.snd_req   = snd_req_r;
  assign bus.snd_pakio = shreg[SHW-1 -: PSZ];
  assign bus.snd_last  = snd_last_r;
  assign bus.snd_src   = snd_src_r;
`ifdef NS_PAKOUT_PARITY_EN
  assign bus.snd_par   = ^shreg[SHW-1 -: PSZ];
`endif

  assign busy = (state != S_IDLE) | (|nempty);

endmodule

// File: tb/tb_pakout_rr.sv
// ---------------------------------------------------------------------------
// tb_pakout_rr
//   Self-checking bench for pakout_rr (default parameters: NCH=2, PSZ=8,
//   MSZ=18, NPK=3, DEPTH=4). Reference model: per-channel queues of the
//   messages handed to the block; every delivered message must be the oldest
//   outstanding one of the channel it claims, split MS packet first.
// ---------------------------------------------------------------------------
module tb_pakout_rr;
  localparam int NCH  = 2;
  localparam int PSZ  = 8;
  localparam int MSZ  = 18;
  localparam int NPK  = 3;
  localparam int SRCW = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic ready;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [MSZ-1:0] q0[$];
  logic [MSZ-1:0] q1[$];

  pakout_rr_if #(.NCH(NCH), .MSZ(MSZ), .PSZ(PSZ), .SRCW(SRCW)) bus();

  pakout_rr #(
    .NCH(NCH), .PSZ(PSZ), .ASZ(6), .DSZ(8), .RSZ(4), .DEPTH_LOG2(2)
  ) dut (
    .i_clk   (clk),
    .reset_n (reset_n),
    .ready   (ready),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.rcv_req = '0;
    bus.snd_ack = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send_msg(input int ch, input logic [MSZ-1:0] msg, output bit ok);
    int n;
    ok = 1'b1;
    bus.rcv_msg[ch*MSZ +: MSZ] = msg;
    bus.rcv_req[ch] = 1'b1;
    n = 0;
    while (bus.rcv_ack[ch] !== 1'b1 && n < 1000) begin tick(); n++; end
    if (bus.rcv_ack[ch] !== 1'b1) ok = 1'b0;
    bus.rcv_req[ch] = 1'b0;
    n = 0;
    while (bus.rcv_ack[ch] !== 1'b0 && n < 1000) begin tick(); n++; end
    if (bus.rcv_ack[ch] !== 1'b0) ok = 1'b0;
  endtask

  // Receives one message: pkts holds the packets MS first, lasts[p]/pars[p]
  // describe packet p; ok clears on timeout or unstable payload/source.
  task automatic recv_msg(input int max_delay, output logic [NPK*PSZ-1:0] pkts,
                          output logic [NPK-1:0] lasts, output logic [SRCW-1:0] src,
                          output logic [NPK-1:0] pars, output logic [NPK-1:0] par_exp,
                          output bit ok);
    int n;
    logic [PSZ-1:0] pk;
    ok = 1'b1;
    pkts = '0;
    lasts = '0;
    src = '0;
    pars = '0;
    par_exp = '0;
    for (int p = 0; p < NPK; p++) begin
      n = 0;
      while (bus.snd_req !== 1'b1 && n < 1000) begin tick(); n++; end
      if (bus.snd_req !== 1'b1) begin ok = 1'b0; return; end
      pk = bus.snd_pakio;
      pkts = {pkts[NPK*PSZ-PSZ-1:0], pk};
      lasts[p] = bus.snd_last;
      if (p == 0) src = bus.snd_src;
      else if (bus.snd_src !== src) ok = 1'b0;
`ifdef NS_PAKOUT_PARITY_EN
      pars[p] = bus.snd_par;
`else
      pars[p] = ^pk;
`endif
      par_exp[p] = ^pk;
      repeat ($urandom_range(max_delay, 0)) begin
        tick();
        if (bus.snd_pakio !== pk || bus.snd_req !== 1'b1) ok = 1'b0;
      end
      bus.snd_ack = 1'b1;
      n = 0;
      while (bus.snd_req !== 1'b0 && n < 1000) begin
        tick(); n++;
        if (bus.snd_pakio !== pk) ok = 1'b0;
      end
      if (bus.snd_req !== 1'b0) ok = 1'b0;
      bus.snd_ack = 1'b0;
    end
  endtask

  task automatic producer(input int ch, input int cnt, input int maxgap, output int bad);
    logic [MSZ-1:0] m;
    bit ok;
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      m = MSZ'($urandom);
      if (ch == 0) q0.push_back(m); else q1.push_back(m);
      send_msg(ch, m, ok);
      if (!ok) bad++;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    bit ok;
    int n;
    bus.rcv_req = '0;
    bus.rcv_msg = '0;
    bus.snd_ack = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({ready, busy, bus.snd_req, bus.snd_last, bus.rcv_ack} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 000000", {ready, busy, bus.snd_req, bus.snd_last, bus.rcv_ack});
    end
    n_cmp++;
    if (bus.snd_pakio !== 8'h00 || bus.snd_src !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: got pakio=%h src=%h expected 00/0", bus.snd_pakio, bus.snd_src);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b expected 0", ready); end
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b expected 1", ready); end

    send_msg(0, 18'h3FFFF, ok);
    n = 0;
    while (bus.snd_req !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++;
    if (!ok || bus.snd_req !== 1'b1) begin
      n_err++; $display("FAIL reset_setup_send: got ok=%0d req=%b expected 1/1", ok, bus.snd_req);
    end
    bus.rcv_msg[MSZ +: MSZ] = 18'h12345;
    bus.rcv_req[1] = 1'b1;
    n = 0;
    while (bus.rcv_ack[1] !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++;
    if (bus.rcv_ack[1] !== 1'b1) begin n_err++; $display("FAIL reset_setup_ack: got %b expected 1", bus.rcv_ack[1]); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.snd_req, bus.rcv_ack, ready, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_send: got req/ack/ready/busy=%b expected 00000", {bus.snd_req, bus.rcv_ack, ready, busy});
    end
    bus.rcv_req = '0;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (bus.snd_req !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_discard: got req=%b busy=%b ready=%b expected 0/0/1", bus.snd_req, busy, ready);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_msg();
    logic [NPK*PSZ-1:0] pkts;
    logic [NPK-1:0] lasts, pars, pe;
    logic [SRCW-1:0] src;
    bit ok;
    int n;
    bus.rcv_msg[0 +: MSZ] = 18'h2B0F5;
    bus.rcv_req[0] = 1'b1;
    n = 0;
    while (bus.rcv_ack[0] !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++;
    if (bus.rcv_ack[0] !== 1'b1 || bus.snd_req !== 1'b0) begin
      n_err++; $display("FAIL single_push: got ack=%b req=%b expected 1/0", bus.rcv_ack[0], bus.snd_req);
    end
    tick();
    n_cmp++;
    if (bus.snd_req !== 1'b1) begin n_err++; $display("FAIL single_latency: got req=%b expected 1", bus.snd_req); end
    bus.rcv_req[0] = 1'b0;
    recv_msg(0, pkts, lasts, src, pars, pe, ok);
    n_cmp++;
    if (!ok || pkts !== 24'h02B0F5) begin
      n_err++; $display("FAIL single_packets: got %h ok=%0d expected 02b0f5", pkts, ok);
    end
    n_cmp++;
    if (lasts !== 3'b100 || src !== 1'b0) begin
      n_err++; $display("FAIL single_last_src: got last=%b src=%0d expected 100/0", lasts, src);
    end
`ifdef NS_PAKOUT_PARITY_EN
    n_cmp++;
    if (pars !== 3'b011) begin n_err++; $display("FAIL single_parity: got %b expected 011", pars); end
`endif
  endtask

  // -------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic [MSZ-1:0] a [2];
    logic [MSZ-1:0] b [2];
    logic [MSZ-1:0] expm [4];
    logic [NPK*PSZ-1:0] pkts;
    logic [NPK-1:0] lasts, pars, pe;
    logic [SRCW-1:0] src;
    bit ok;
    int n;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      a[r] = MSZ'($urandom);
      b[r] = MSZ'($urandom);
      expm[2*r] = a[r];
      expm[2*r+1] = b[r];
      bus.rcv_msg = {b[r], a[r]};
      bus.rcv_req = 2'b11;
      n = 0;
      while (bus.rcv_ack === 2'b00 && n < 10) begin tick(); n++; end
      n_cmp++;
      if (bus.rcv_ack !== 2'b11) begin n_err++; $display("FAIL simul_ack_r%0d: got %b expected 11", r, bus.rcv_ack); end
      bus.rcv_req = 2'b00;
      n = 0;
      while (bus.rcv_ack !== 2'b00 && n < 10) begin tick(); n++; end
    end
    for (int i = 0; i < 4; i++) begin
      recv_msg(1, pkts, lasts, src, pars, pe, ok);
      n_cmp++;
      if (!ok || src !== SRCW'(i % 2) || pkts !== 24'(expm[i]) || lasts !== 3'b100) begin
        n_err++;
        $display("FAIL simul_order_%0d: got src=%0d msg=%h last=%b ok=%0d expected src=%0d msg=%h last=100",
                 i, src, pkts, lasts, ok, i % 2, expm[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fifo_full();
    logic [MSZ-1:0] x;
    logic [MSZ-1:0] m [5];
    logic [NPK*PSZ-1:0] pkts;
    logic [NPK-1:0] lasts, pars, pe;
    logic [SRCW-1:0] src;
    bit ok, stalled_ok;
    int n, acks;
    bus.snd_ack = 1'b0;
    x = MSZ'($urandom);
    send_msg(0, x, ok);
    n = 0;
    while (bus.snd_req !== 1'b1 && n < 10) begin tick(); n++; end
    acks = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = MSZ'($urandom);
      send_msg(1, m[i], ok);
      if (ok) acks++;
    end
    n_cmp++;
    if (acks != DEPTH) begin n_err++; $display("FAIL full_accept: got %0d acks expected %0d", acks, DEPTH); end
    m[4] = MSZ'($urandom);
    bus.rcv_msg[MSZ +: MSZ] = m[4];
    bus.rcv_req[1] = 1'b1;
    stalled_ok = 1'b1;
    repeat (10) begin tick(); if (bus.rcv_ack[1] !== 1'b0) stalled_ok = 1'b0; end
    n_cmp++;
    if (!stalled_ok) begin n_err++; $display("FAIL full_stall: got ack=1 while full expected 0"); end
    recv_msg(0, pkts, lasts, src, pars, pe, ok);
    n_cmp++;
    if (!ok || src !== 1'b0 || pkts !== 24'(x)) begin
      n_err++; $display("FAIL full_first: got src=%0d msg=%h ok=%0d expected 0/%h", src, pkts, ok, x);
    end
    n = 0;
    while (bus.rcv_ack[1] !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++;
    if (bus.rcv_ack[1] !== 1'b1) begin n_err++; $display("FAIL full_release: got ack=%b expected 1", bus.rcv_ack[1]); end
    bus.rcv_req[1] = 1'b0;
    n = 0;
    while (bus.rcv_ack[1] !== 1'b0 && n < 10) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      recv_msg(0, pkts, lasts, src, pars, pe, ok);
      n_cmp++;
      if (!ok || src !== 1'b1 || pkts !== 24'(m[i])) begin
        n_err++; $display("FAIL full_drain_%0d: got src=%0d msg=%h ok=%0d expected 1/%h", i, src, pkts, ok, m[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_no_starve();
    logic [NPK*PSZ-1:0] pkts;
    logic [NPK-1:0] lasts, pars, pe;
    logic [SRCW-1:0] src;
    logic [MSZ-1:0] e;
    bit ok, ch1_acked, got1;
    int between, bad0, bad1, bad_rx;
    q0.delete(); q1.delete();
    ch1_acked = 1'b0; got1 = 1'b0; between = 0; bad_rx = 0; bad1 = 0;
    fork
      producer(0, 8, 0, bad0);
      begin
        logic [MSZ-1:0] m1;
        repeat (15) tick();
        m1 = MSZ'($urandom);
        q1.push_back(m1);
        send_msg(1, m1, ok);
        if (!ok) bad1++;
        ch1_acked = 1'b1;
      end
      for (int i = 0; i < 9; i++) begin
        recv_msg(1, pkts, lasts, src, pars, pe, ok);
        e = '1;
        if (src == 1'b0 && q0.size() > 0) e = q0.pop_front();
        else if (src == 1'b1 && q1.size() > 0) e = q1.pop_front();
        else ok = 1'b0;
        if (!ok || pkts !== 24'(e) || lasts !== 3'b100) bad_rx++;
        if (src == 1'b1) got1 = 1'b1;
        else if (ch1_acked && !got1) between++;
      end
    join
    n_cmp++;
    if (bad0 + bad1 + bad_rx != 0) begin
      n_err++; $display("FAIL starve_content: got %0d bad transfers expected 0", bad0 + bad1 + bad_rx);
    end
    n_cmp++;
    if (!got1 || between > 1) begin
      n_err++; $display("FAIL starve_wait: got served=%0d ch0_before=%0d expected 1/<=1", got1, between);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    logic [NPK*PSZ-1:0] pkts;
    logic [NPK-1:0] lasts, pars, pe;
    logic [SRCW-1:0] src;
    logic [MSZ-1:0] e;
    bit ok;
    int bad0, bad1;
    q0.delete(); q1.delete();
    fork
      producer(0, 10, 3, bad0);
      producer(1, 10, 3, bad1);
      for (int i = 0; i < 20; i++) begin
        recv_msg(3, pkts, lasts, src, pars, pe, ok);
        e = '1;
        if (src == 1'b0 && q0.size() > 0) e = q0.pop_front();
        else if (src == 1'b1 && q1.size() > 0) e = q1.pop_front();
        else ok = 1'b0;
        n_cmp++;
        if (!ok || pkts !== 24'(e) || lasts !== 3'b100) begin
          n_err++;
          $display("FAIL random_msg_%0d: got src=%0d msg=%h last=%b ok=%0d expected msg=%h last=100",
                   i, src, pkts, lasts, ok, e);
        end
`ifdef NS_PAKOUT_PARITY_EN
        n_cmp++;
        if (pars !== pe) begin n_err++; $display("FAIL random_par_%0d: got %b expected %b", i, pars, pe); end
`endif
      end
    join
    n_cmp++;
    if (bad0 + bad1 != 0) begin n_err++; $display("FAIL random_push: got %0d stuck pushes expected 0", bad0 + bad1); end
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || bus.snd_req !== 1'b0) begin
      n_err++; $display("FAIL random_idle: got busy=%b req=%b expected 0/0", busy, bus.snd_req);
    end
  endtask

  initial begin
    test_reset();
    test_single_msg();
    test_simultaneous();
    test_fifo_full();
    test_no_starve();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
